// File: rtl/lfsr_stream_checker_pkg.sv
// Shared definitions for the 22-bit LFSR stream checker: LFSR geometry,
// FSM state encoding and the generator's default seed.
package lfsr_stream_checker_pkg;

    localparam int LFSR_W = 22;
    localparam int TAP_HI = 21;
    localparam int TAP_LO = 20;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 22'b0001011001001110011111;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr_stream_checker_if.sv
// Serial stream input and status outputs of the LFSR stream checker.
interface lfsr_stream_checker_if #(
    parameter int CNT_W = 16
);
    logic             sh_en;
    logic             bit_in;
    logic             locked;
    logic             err_pulse;
    logic             sync_loss;
    logic [CNT_W-1:0] err_count;

    modport master (
        output sh_en,
        output bit_in,
        input  locked,
        input  err_pulse,
        input  sync_loss,
        input  err_count
    );

    modport slave (
        input  sh_en,
        input  bit_in,
        output locked,
        output err_pulse,
        output sync_loss,
        output err_count
    );
endinterface

// File: rtl/lfsr_hist_reg.sv
// Local copy of the generator: 22-bit history shift register that shifts in
// either the received bit or its own prediction.
module lfsr_hist_reg
    import lfsr_stream_checker_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sel_pred,
    input  logic bit_in,
    output logic pred,
    output logic zero_next
);

    logic [LFSR_W-1:0] hist_reg;
    logic [LFSR_W-1:0] hist_next;

    always_comb begin
        pred      = hist_reg[TAP_HI] ^ hist_reg[TAP_LO];
        hist_next = {hist_reg[LFSR_W-2:0], (sel_pred ? pred : bit_in)};
        // Flag describes the value the register would hold after this shift.
        zero_next = (hist_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= '0;
        end else if (en) begin
            hist_reg <= hist_next;
        end
    end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the 22-bit LFSR stream: acquires the
// generator state, verifies it, then counts bit errors and detects sync loss.
module lfsr_stream_checker
    import lfsr_stream_checker_pkg::*;
#(
    parameter int LOCK_RUN   = 32,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lfsr_stream_checker_if.slave bus
);

    localparam int FILL_W = $clog2(LFSR_W + 1);
    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int ERR_W  = $clog2(ERR_THRESH + 1);

    state_e             state_reg, state_next;
    logic [FILL_W-1:0]  fill_cnt_reg, fill_cnt_next;
    logic [RUN_W-1:0]   run_cnt_reg, run_cnt_next;
    logic [WIN_W-1:0]   win_cnt_reg, win_cnt_next;
    logic [ERR_W-1:0]   win_err_reg, win_err_next;
    logic [ERR_W-1:0]   win_err_inc;
    logic [CNT_W-1:0]   err_count_reg, err_count_next;
    logic               locked_reg, locked_next;
    logic               err_pulse_reg, err_pulse_next;
    logic               sync_loss_reg, sync_loss_next;

    logic hist_en;
    logic hist_sel_pred;
    logic pred;
    logic hist_zero_next;
    logic mismatch;

    // Once locked the local copy free-runs so channel errors cannot corrupt it.
    assign hist_en       = bus.sh_en;
    assign hist_sel_pred = (state_reg == ST_LOCKED);
    assign mismatch      = bus.bit_in ^ pred;
    assign win_err_inc   = win_err_reg + ERR_W'(1);

    lfsr_hist_reg u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (hist_en),
        .sel_pred  (hist_sel_pred),
        .bit_in    (bus.bit_in),
        .pred      (pred),
        .zero_next (hist_zero_next)
    );

    always_comb begin
        state_next     = state_reg;
        fill_cnt_next  = fill_cnt_reg;
        run_cnt_next   = run_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        err_count_next = err_count_reg;
        err_pulse_next = 1'b0;
        sync_loss_next = 1'b0;

        if (bus.sh_en) begin
            unique case (state_reg)
                ST_LOAD: begin
                    if (fill_cnt_reg == FILL_W'(LFSR_W - 1)) begin
                        fill_cnt_next = '0;
                        // An all-zero fill is the lockup pattern; refill instead.
                        if (!hist_zero_next) begin
                            state_next   = ST_VERIFY;
                            run_cnt_next = '0;
                        end
                    end else begin
                        fill_cnt_next = fill_cnt_reg + FILL_W'(1);
                    end
                end

                ST_VERIFY: begin
                    if (mismatch) begin
                        state_next    = ST_LOAD;
                        fill_cnt_next = '0;
                        run_cnt_next  = '0;
                    end else begin
                        run_cnt_next = run_cnt_reg + RUN_W'(1);
                        if (run_cnt_reg == RUN_W'(LOCK_RUN - 1)) begin
                            state_next   = ST_LOCKED;
                            win_cnt_next = '0;
                            win_err_next = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        win_err_next   = win_err_inc;
                        if (err_count_reg != '1) begin
                            err_count_next = err_count_reg + CNT_W'(1);
                        end
                    end
                    // Threshold check comes first so loss wins over window rollover.
                    if (mismatch && (win_err_inc == ERR_W'(ERR_THRESH))) begin
                        sync_loss_next = 1'b1;
                        state_next     = ST_LOAD;
                        fill_cnt_next  = '0;
                        run_cnt_next   = '0;
                        win_cnt_next   = '0;
                        win_err_next   = '0;
                    end else if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                    end
                end

                default: begin
                    state_next    = ST_LOAD;
                    fill_cnt_next = '0;
                    run_cnt_next  = '0;
                end
            endcase
        end

        locked_next = (state_next == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_LOAD;
            fill_cnt_reg  <= '0;
            run_cnt_reg   <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            err_count_reg <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            sync_loss_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fill_cnt_reg  <= fill_cnt_next;
            run_cnt_reg   <= run_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            err_count_reg <= err_count_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            sync_loss_reg <= sync_loss_next;
        end
    end

    assign bus.locked    = locked_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.sync_loss = sync_loss_reg;
    assign bus.err_count = err_count_reg;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker: a reference generator drives the
// stream, expected outputs are queued per cycle and compared a cycle later.
module tb_lfsr_stream_checker;
    import lfsr_stream_checker_pkg::*;

    localparam int LOCK_RUN   = 32;
    localparam int WINDOW     = 64;
    localparam int ERR_THRESH = 4;
    localparam int CNT_W      = 16;
    localparam int LOCK_LAT   = LFSR_W + LOCK_RUN;

    typedef enum int {SRC_GEN, SRC_ZERO, SRC_ONE} src_e;

    typedef struct packed {
        logic             locked;
        logic             err_pulse;
        logic             sync_loss;
        logic [CNT_W-1:0] err_count;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    lfsr_stream_checker_if #(.CNT_W(CNT_W)) bus ();

    lfsr_stream_checker #(
        .LOCK_RUN   (LOCK_RUN),
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    exp_t              sb_q[$];
    logic [LFSR_W-1:0] gen_q;
    src_e              src;

    // Expected-behaviour bookkeeping, in stream terms.
    logic              m_locked;
    int                m_acq;
    int                m_win_pos;
    int                m_win_err;
    logic [CNT_W-1:0]  m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_locked  = 1'b0;
        m_acq     = 0;
        m_win_pos = 0;
        m_win_err = 0;
        m_cnt     = '0;
    endtask

    task automatic check_pending();
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("locked",    32'(bus.locked),    32'(e.locked));
            chk("err_pulse", 32'(bus.err_pulse), 32'(e.err_pulse));
            chk("sync_loss", 32'(bus.sync_loss), 32'(e.sync_loss));
            chk("err_count", 32'(bus.err_count), 32'(e.err_count));
        end
    endtask

    // One clock cycle: check last cycle's result, drive this cycle, queue expectation.
    task automatic step(input logic en, input logic flip);
        logic b;
        exp_t e;
        @(negedge clk);
        check_pending();
        b = 1'($urandom);
        e = '0;
        if (en) begin
            case (src)
                SRC_GEN: begin
                    b     = gen_q[LFSR_W-1];
                    gen_q = {gen_q[LFSR_W-2:0], gen_q[TAP_HI] ^ gen_q[TAP_LO]};
                end
                SRC_ZERO: b = 1'b0;
                default:  b = 1'b1;
            endcase
            b = b ^ flip;

            if (!m_locked) begin
                if (src == SRC_GEN) begin
                    m_acq++;
                    if (m_acq == LOCK_LAT) begin
                        m_locked  = 1'b1;
                        m_win_pos = 0;
                        m_win_err = 0;
                    end
                end
            end else begin
                if (flip) begin
                    e.err_pulse = 1'b1;
                    m_win_err++;
                    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                    $display("xfer: error injected, expected err_count=%0d window_errs=%0d", m_cnt, m_win_err);
                end
                if (flip && m_win_err == ERR_THRESH) begin
                    e.sync_loss = 1'b1;
                    m_locked    = 1'b0;
                    m_acq       = 0;
                    m_win_pos   = 0;
                    m_win_err   = 0;
                end else begin
                    m_win_pos++;
                    if (m_win_pos == WINDOW) begin
                        m_win_pos = 0;
                        m_win_err = 0;
                    end
                end
            end
        end
        bus.sh_en  = en;
        bus.bit_in = b;
        e.locked    = m_locked;
        e.err_count = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic strobes(input int n);
        repeat (n) step(1'b1, 1'b0);
    endtask

    // Clean bits until the expected window position is reached (bounded).
    task automatic align_win(input int pos);
        int guard;
        guard = 0;
        while (m_win_pos != pos && guard < 2 * WINDOW) begin
            step(1'b1, 1'b0);
            guard++;
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        check_pending();
        bus.sh_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_locked",    32'(bus.locked),    32'd0);
        chk("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        chk("rst_sync_loss", 32'(bus.sync_loss), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        e = '0;
        sb_q.push_back(e);
        $display("xfer: reset applied");
    endtask

    initial begin
        bus.sh_en  = 1'b0;
        bus.bit_in = 1'b0;
        gen_q      = DEFAULT_SEED;
        src        = SRC_GEN;
        model_clear();

        do_reset();

        $display("xfer: clean stream, sh_en every cycle");
        strobes(LOCK_LAT + 10000);

        $display("xfer: single bit error while locked");
        step(1'b1, 1'b1);
        strobes(100);

        $display("xfer: four errors ending on the window-completing bit");
        align_win(WINDOW - ERR_THRESH);
        repeat (ERR_THRESH) step(1'b1, 1'b1);

        $display("xfer: reset mid-verify at bit 40");
        strobes(40);
        do_reset();
        strobes(LOCK_LAT + 20);

        $display("xfer: three errors, window rolls, one more error");
        align_win(0);
        step(1'b1, 1'b1);
        strobes(3);
        step(1'b1, 1'b1);
        strobes(3);
        step(1'b1, 1'b1);
        align_win(0);
        step(1'b1, 1'b1);
        strobes(10);

        $display("xfer: clean stream, sh_en one cycle in five");
        do_reset();
        repeat (LOCK_LAT + 10) begin
            step(1'b1, 1'b0);
            repeat (4) step(1'b0, 1'b0);
        end

        $display("xfer: constant zero stream");
        do_reset();
        src = SRC_ZERO;
        strobes(500);

        $display("xfer: constant one stream");
        do_reset();
        src = SRC_ONE;
        strobes(500);

        step(1'b0, 1'b0);
        @(negedge clk);
        check_pending();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
